// File: rtl/lcd1602_pkg.sv
// Shared constants, FSM state type and init ROM for the 1602 LCD bus blocks.
package lcd1602_pkg;

    // HD44780 command bytes used by the init sequence and long-command detection
    localparam logic [7:0] MODE_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] ENTRY_INC = 8'h06;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] HOME      = 8'h02;

    localparam int unsigned INIT_DEPTH = 4;
    localparam int unsigned INIT_IDX_W = $clog2(INIT_DEPTH);

    typedef enum logic [2:0] {
        StPwr,
        StIdle,
        StSetup,
        StEnHi,
        StEnLo,
        StWait
    } state_e;

    function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = MODE_SET;
            2'd1:    cmd = DISP_ON;
            2'd2:    cmd = ENTRY_INC;
            default: cmd = CLEAR;
        endcase
        return cmd;
    endfunction

    // Clear and Home need the extended post-strobe wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CLEAR || data == HOME);
    endfunction

endpackage

// File: rtl/lcd1602_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clk cycles.
// rst_n is an asynchronous, active-high reset despite its name.
module lcd1602_tick_gen #(
    parameter int unsigned TICK_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Divider counter, wraps on tick
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/lcd1602_bus_arbiter.sv
// Runs the LCD power-on init sequence, then round-robin arbitrates two write
// requesters and serialises each accepted byte into a timed RS/DATA/EN cycle.
// rst_n is an asynchronous, active-high reset despite its name.
module lcd1602_bus_arbiter
    import lcd1602_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 25000,
    parameter int unsigned INIT_TICKS  = 40,
    parameter int unsigned CLEAR_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int unsigned PWR_W  = $clog2(INIT_TICKS + 1);
    localparam int unsigned WAIT_W = $clog2(CLEAR_TICKS + 1);

    logic tick;

    state_e                state_q, state_d;
    logic [INIT_IDX_W-1:0] init_idx_q, init_idx_d;
    logic [PWR_W-1:0]      pwr_cnt_q, pwr_cnt_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  hold_rs_q, hold_rs_d;
    logic [7:0]            hold_data_q, hold_data_d;
    logic                  prio1_q, prio1_d;  // 1: req1 wins a tie
    logic                  init_done_q, init_done_d;
    logic                  lcd_rs_q, lcd_rs_d;
    logic                  lcd_en_q, lcd_en_d;
    logic [7:0]            lcd_data_q, lcd_data_d;
    logic                  ready0_q, ready0_d;
    logic                  ready1_q, ready1_d;
    logic                  grant1;

    lcd1602_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign grant1     = req1_valid && (!req0_valid || prio1_q);
    assign busy       = (state_q != StIdle);
    assign init_done  = init_done_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = lcd_en_q;
    assign lcd_data   = lcd_data_q;
    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;

    // State and output registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= StPwr;
            init_idx_q  <= '0;
            pwr_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            hold_rs_q   <= 1'b0;
            hold_data_q <= 8'h00;
            prio1_q     <= 1'b0;
            init_done_q <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            pwr_cnt_q   <= pwr_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            hold_rs_q   <= hold_rs_d;
            hold_data_q <= hold_data_d;
            prio1_q     <= prio1_d;
            init_done_q <= init_done_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_en_q    <= lcd_en_d;
            lcd_data_q  <= lcd_data_d;
            ready0_q    <= ready0_d;
            ready1_q    <= ready1_d;
        end
    end

    // Next-state: init sequencing, arbitration and bus cycle generation
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        pwr_cnt_d   = pwr_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        hold_rs_d   = hold_rs_q;
        hold_data_d = hold_data_q;
        prio1_d     = prio1_q;
        init_done_d = init_done_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_en_d    = lcd_en_q;
        lcd_data_d  = lcd_data_q;
        ready0_d    = 1'b0;
        ready1_d    = 1'b0;

        unique case (state_q)
            StPwr: begin
                if (tick) begin
                    if (pwr_cnt_q == PWR_W'(INIT_TICKS - 1)) begin
                        init_idx_d  = '0;
                        hold_rs_d   = 1'b0;
                        hold_data_d = init_rom('0);
                        state_d     = StSetup;
                    end else begin
                        pwr_cnt_d = pwr_cnt_q + 1'b1;
                    end
                end
            end
            StIdle: begin
                // Not tick-gated: accept on any cycle
                if (init_done_q && (req0_valid || req1_valid)) begin
                    if (grant1) begin
                        ready1_d    = 1'b1;
                        hold_rs_d   = req1_rs;
                        hold_data_d = req1_data;
                        prio1_d     = 1'b0;
                    end else begin
                        ready0_d    = 1'b1;
                        hold_rs_d   = req0_rs;
                        hold_data_d = req0_data;
                        prio1_d     = 1'b1;
                    end
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    lcd_rs_d   = hold_rs_q;
                    lcd_data_d = hold_data_q;
                    lcd_en_d   = 1'b0;
                    state_d    = StEnHi;
                end
            end
            StEnHi: begin
                if (tick) begin
                    lcd_en_d = 1'b1;
                    state_d  = StEnLo;
                end
            end
            StEnLo: begin
                if (tick) begin
                    lcd_en_d   = 1'b0;
                    wait_cnt_d = is_long_cmd(hold_rs_q, hold_data_q) ?
                                 WAIT_W'(CLEAR_TICKS) : WAIT_W'(1);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (tick) begin
                    if (wait_cnt_q <= WAIT_W'(1)) begin
                        wait_cnt_d = '0;
                        if (init_done_q) begin
                            state_d = StIdle;
                        end else if (init_idx_q == INIT_IDX_W'(INIT_DEPTH - 1)) begin
                            init_done_d = 1'b1;
                            state_d     = StIdle;
                        end else begin
                            init_idx_d  = init_idx_q + 1'b1;
                            hold_rs_d   = 1'b0;
                            hold_data_d = init_rom(init_idx_q + 1'b1);
                            state_d     = StSetup;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = StPwr;
        endcase
    end

endmodule

// File: tb/tb_lcd1602_bus_arbiter.sv
// Self-checking bench for lcd1602_bus_arbiter: scoreboard of expected bus
// writes checked on every EN rise, plus table-driven arbitration vectors.
module tb_lcd1602_bus_arbiter;

    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned INIT_TICKS  = 2;
    localparam int unsigned CLEAR_TICKS = 4;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic       v0;
        logic       rs0;
        logic [7:0] d0;
        logic       v1;
        logic       rs1;
        logic [7:0] d1;
        logic       g1;
        int         ticks;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready, init_done, busy;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t exp_q[$];

    // Bench-side tick reference
    int   tb_div;
    logic tb_tick;

    always #5 clk = ~clk;

    lcd1602_bus_arbiter #(
        .TICK_DIV    (TICK_DIV),
        .INIT_TICKS  (INIT_TICKS),
        .CLEAR_TICKS (CLEAR_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .init_done  (init_done),
        .busy       (busy),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data   (lcd_data)
    );

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) tb_div <= 0;
        else       tb_div <= (tb_div == int'(TICK_DIV) - 1) ? 0 : tb_div + 1;
    end
    assign tb_tick = (tb_div == int'(TICK_DIV) - 1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not observed as required", name);
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now(name);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(req0_ready || req1_ready)) fail_now(name);
    endtask

    // Scoreboard monitor: pops on EN rise, checks setup/hold and EN width
    logic prev_en;
    int   en_cnt;
    wr_t  prev_bus, rise_bus, exp_w;
    always @(negedge clk) begin
        if (rst_n) begin
            prev_en  = 1'b0;
            en_cnt   = 0;
            prev_bus = '0;
        end else begin
            if (req0_ready || req1_ready) check("ready_only_after_init", 32'(init_done), 1);
            if (lcd_en && !prev_en) begin
                check("bus_setup_stable", 32'({lcd_rs, lcd_data}), 32'(prev_bus));
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_strobe");
                end else begin
                    exp_w = exp_q.pop_front();
                    check("strobe_byte", 32'({lcd_rs, lcd_data}), 32'(exp_w));
                end
                rise_bus = {lcd_rs, lcd_data};
                en_cnt   = 1;
            end else if (lcd_en) begin
                en_cnt++;
            end else if (prev_en) begin
                check("en_width", 32'(en_cnt), 32'(TICK_DIV));
                check("bus_hold_stable", 32'({lcd_rs, lcd_data}), 32'(rise_bus));
            end
            prev_en  = lcd_en;
            prev_bus = {lcd_rs, lcd_data};
        end
    end

    vec_t vecs[8];

    initial begin
        int n, t;
        vec_t v;

        vecs[0] = '{1'b1, 1'b1, 8'h43, 1'b0, 1'b0, 8'h00, 1'b0, 4};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b1, 4};
        vecs[2] = '{1'b1, 1'b1, 8'h31, 1'b1, 1'b1, 8'h32, 1'b0, 4};
        vecs[3] = '{1'b1, 1'b1, 8'h31, 1'b1, 1'b1, 8'h32, 1'b1, 4};
        vecs[4] = '{1'b1, 1'b1, 8'h35, 1'b1, 1'b1, 8'h36, 1'b0, 4};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 7};
        vecs[6] = '{1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 4};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b1, 7};

        // Reset values while held in reset
        #23;
        check("rst_lcd_en", 32'(lcd_en), 0);
        check("rst_lcd_rs", 32'(lcd_rs), 0);
        check("rst_lcd_data", 32'(lcd_data), 0);
        check("rst_lcd_rw", 32'(lcd_rw), 0);
        check("rst_ready", 32'({req1_ready, req0_ready}), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_busy", 32'(busy), 1);

        // Init sequence with req0 held valid throughout
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h4B;
        @(negedge clk);
        rst_n = 1'b0;
        push_init();
        exp_q.push_back({1'b1, 8'h4B});

        n = 0;
        while (!(lcd_en && lcd_data == 8'h01) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!(lcd_en && lcd_data == 8'h01)) fail_now("init_clear_strobe");
        n = 0;
        while (lcd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = 0;
        n = 0;
        while (!init_done && n < 100) begin
            if (tb_tick) t++;
            @(negedge clk);
            n++;
        end
        if (!init_done) fail_now("init_done_rise");
        check("clear_wait_ticks", 32'(t), 32'(CLEAR_TICKS));
        check("idle_after_init", 32'(busy), 0);
        @(negedge clk);
        check("accept_first_idle", 32'({req1_ready, req0_ready}), 32'b01);
        req0_valid = 1'b0;
        wait_idle("held_req_done");

        // Table-driven arbitration vectors
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            wait_idle("vec_idle");
            req0_valid = v.v0; req0_rs = v.rs0; req0_data = v.d0;
            req1_valid = v.v1; req1_rs = v.rs1; req1_data = v.d1;
            if (v.g1) exp_q.push_back({v.rs1, v.d1});
            else      exp_q.push_back({v.rs0, v.d0});
            wait_ready("vec_ready");
            check("vec_grant", 32'({req1_ready, req0_ready}), v.g1 ? 32'b10 : 32'b01);
            check("vec_busy_with_ready", 32'(busy), 1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            t = tb_tick ? 1 : 0;
            @(negedge clk);
            check("vec_ready_one_cycle", 32'({req1_ready, req0_ready}), 0);
            n = 0;
            while (busy && n < 200) begin
                if (tb_tick) t++;
                @(negedge clk);
                n++;
            end
            if (busy) fail_now("vec_busy_fall");
            check("vec_transfer_ticks", 32'(t), 32'(v.ticks));
        end

        // Both held: loser keeps valid and is served next, order alternates
        for (int r = 0; r < 2; r++) begin
            wait_idle("held_idle");
            req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h33;
            req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h34;
            exp_q.push_back({1'b1, 8'h33});
            exp_q.push_back({1'b1, 8'h34});
            wait_ready("held_first_ready");
            check("held_first_grant", 32'({req1_ready, req0_ready}), 32'b01);
            req0_valid = 1'b0;
            @(negedge clk);
            wait_ready("held_second_ready");
            check("held_second_grant", 32'({req1_ready, req0_ready}), 32'b10);
            req1_valid = 1'b0;
        end

        // Reset asserted while EN is high
        wait_idle("rst_test_idle");
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
        exp_q.push_back({1'b1, 8'h55});
        wait_ready("rst_test_ready");
        req0_valid = 1'b0;
        n = 0;
        while (!lcd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!lcd_en) fail_now("rst_test_en_high");
        #2 rst_n = 1'b1;
        #1;
        check("midrst_lcd_en", 32'(lcd_en), 0);
        check("midrst_lcd_data", 32'({lcd_rs, lcd_data}), 0);
        check("midrst_busy_done", 32'({busy, init_done}), 32'b10);
        check("midrst_queue_drained", 32'(exp_q.size()), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        push_init();
        n = 0;
        while (!init_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!init_done) fail_now("reinit_done");
        check("reinit_idle", 32'(busy), 0);
        check("reinit_last_byte", 32'({lcd_rs, lcd_data}), 32'h001);
        repeat (20) @(negedge clk);
        check("reinit_no_extra_strobe", 32'(lcd_en), 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
